pe_mac_param: RTL and testbench

PE_MAC_PARAM -- requirements
Module: pe_mac_param

---
 rtl/pe_pkg.sv | 41 ++++
 rtl/pe_mul_stage.sv | 51 +++++
 rtl/pe_mac_param.sv | 103 ++++++++++
 tb/tb_pe_mac_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants and saturating accumulate helper for the MAC processing element
package pe_pkg;

    localparam int PE_DATA_W = 16;
    localparam int PE_ACC_W  = 2*PE_DATA_W+1;

    // Working width for the saturating add; every accumulator width in use must stay well below it.
    localparam int SAT_W = 128;
    localparam logic [SAT_W-1:0] SAT_ONE = {{(SAT_W-1){1'b0}}, 1'b1};

    // Operands arrive already extended to SAT_W; returns {clamped, clamped_sum}.
    function automatic logic [SAT_W:0] sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] prod,
        input int unsigned             acc_w,
        input bit                      is_signed
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic                    clamp;
        sum = acc + prod;
        if (is_signed) begin
            hi = (SAT_ONE << (acc_w - 1)) - SAT_ONE;
            lo = -(SAT_ONE << (acc_w - 1));
        end else begin
            hi = (SAT_ONE << acc_w) - SAT_ONE;
            lo = '0;
        end
        clamp = 1'b0;
        if (sum > hi) begin
            sum   = hi;
            clamp = 1'b1;
        end else if (sum < lo) begin
            sum   = lo;
            clamp = 1'b1;
        end
        return {clamp, sum};
    endfunction

endpackage

// File: rtl/pe_mul_stage.sv
// rtl/pe_mul_stage.sv - full-width multiplier with optional product/fire/clr pipeline register
module pe_mul_stage #(
    parameter int DATA_W   = 16,
    parameter int SIGNED   = 0,
    parameter int PIPE_MUL = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                drain,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                fire,
    input  logic                clr,
    output logic [2*DATA_W-1:0] prod,
    output logic                prod_fire,
    output logic                prod_clr
);

    logic [2*DATA_W-1:0] a_x;
    logic [2*DATA_W-1:0] b_x;
    logic [2*DATA_W-1:0] prod_c;

    // Extending to 2*DATA_W first makes the low half of the product correct for both encodings.
    assign a_x    = {{DATA_W{(SIGNED != 0) & a[DATA_W-1]}}, a};
    assign b_x    = {{DATA_W{(SIGNED != 0) & b[DATA_W-1]}}, b};
    assign prod_c = a_x * b_x;

    generate
        if (PIPE_MUL != 0) begin : g_pipe
            always_ff @(posedge clk) begin
                if (!rst) begin
                    prod      <= '0;
                    prod_fire <= 1'b0;
                    prod_clr  <= 1'b0;
                end else if (en) begin
                    prod      <= prod_c;
                    prod_fire <= fire;
                    prod_clr  <= clr & ~drain;
                end
            end
        end else begin : g_comb
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, en, drain};
            assign prod       = prod_c;
            assign prod_fire  = fire;
            assign prod_clr   = clr;
        end
    endgenerate

endmodule

// File: rtl/pe_mac_param.sv
// rtl/pe_mac_param.sv - systolic MAC processing element with saturating accumulator and drain chain
module pe_mac_param
    import pe_pkg::*;
#(
    parameter int DATA_W   = PE_DATA_W,
    parameter int ACC_W    = 2*DATA_W+1,
    parameter int SIGNED   = 0,
    parameter int PIPE_MUL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              drain,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    input  logic [ACC_W-1:0]  c_in,
    input  logic              c_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    output logic [ACC_W-1:0]  c_out,
    output logic              c_vld_out,
    output logic              ovf
);

    localparam bit IS_SIGNED = (SIGNED != 0);

    logic                fire;
    logic [2*DATA_W-1:0] prod;
    logic                m_fire;
    logic                m_clr;
    logic [SAT_W-1:0]    prod_big;
    logic [SAT_W-1:0]    acc_big;
    logic [SAT_W:0]      sat;
    logic [ACC_W-1:0]    prod_acc;
    logic                unused_sat_bits;

    assign fire = en & a_vld_in & b_vld_in & ~drain;

    pe_mul_stage #(
        .DATA_W   (DATA_W),
        .SIGNED   (SIGNED),
        .PIPE_MUL (PIPE_MUL)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .drain     (drain),
        .a         (a_in),
        .b         (b_in),
        .fire      (fire),
        .clr       (clr),
        .prod      (prod),
        .prod_fire (m_fire),
        .prod_clr  (m_clr)
    );

    assign prod_big        = {{(SAT_W-2*DATA_W){IS_SIGNED & prod[2*DATA_W-1]}}, prod};
    assign acc_big         = {{(SAT_W-ACC_W){IS_SIGNED & c_out[ACC_W-1]}}, c_out};
    assign prod_acc        = prod_big[ACC_W-1:0];
    assign sat             = sat_add(acc_big, prod_big, ACC_W, IS_SIGNED);
    assign unused_sat_bits = ^sat[SAT_W-1:ACC_W];

    // Drain outranks both fire and clr so a chain shift is never corrupted by tile control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_out     <= '0;
            a_vld_out <= 1'b0;
            b_out     <= '0;
            b_vld_out <= 1'b0;
            c_out     <= '0;
            c_vld_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
            b_out     <= b_in;
            b_vld_out <= b_vld_in;
            if (drain) begin
                c_out     <= c_in;
                c_vld_out <= c_vld_in;
            end else if (m_fire) begin
                c_vld_out <= 1'b1;
                if (m_clr) begin
                    c_out <= prod_acc;
                    ovf   <= 1'b0;
                end else begin
                    c_out <= sat[ACC_W-1:0];
                    ovf   <= ovf | sat[SAT_W];
                end
            end else if (m_clr) begin
                c_out     <= '0;
                c_vld_out <= 1'b0;
                ovf       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_param.sv
// tb/tb_pe_mac_param.sv - self-checking bench for pe_mac_param across several parameter sets
module tb_pe_mac_param;

    localparam int DW[6] = '{16, 4, 8, 4, 16, 16};
    localparam int AW[6] = '{33, 8, 17, 8, 33, 33};
    localparam bit SG[6] = '{0, 0, 1, 1, 0, 0};
    localparam bit PM[6] = '{0, 0, 0, 0, 1, 0};

    logic        clk = 1'b0;
    logic        rst, en, clr, drain, av, bv, cv, avt, bvt;
    logic [15:0] a_s, b_s, at, bt;
    logic [32:0] c_s;

    logic [15:0] ao0, bo0, ao4, bo4, ao5, bo5;
    logic [3:0]  ao1, bo1, ao3, bo3;
    logic [7:0]  ao2, bo2;
    logic [32:0] co0, co4, co5;
    logic [16:0] co2;
    logic [7:0]  co1, co3;
    logic [5:0]  aov, bov, cov, ovf;
    logic [63:0] co[6], ao[6], bo[6];

    int n_vec = 0;
    int n_err = 0;

    longint m_acc[6], m_a[6], m_b[6], p_prod[6];
    bit     m_vld[6], m_ovf[6], m_av[6], m_bv[6], p_fire[6], p_clr[6];

    always #5 clk = ~clk;

    pe_mac_param u0 (.clk(clk), .rst(rst), .en(en), .clr(clr), .drain(drain),
        .a_in(a_s), .a_vld_in(av), .b_in(b_s), .b_vld_in(bv), .c_in(c_s), .c_vld_in(cv),
        .a_out(ao0), .a_vld_out(aov[0]), .b_out(bo0), .b_vld_out(bov[0]),
        .c_out(co0), .c_vld_out(cov[0]), .ovf(ovf[0]));
    pe_mac_param #(.DATA_W(4), .ACC_W(8)) u1 (.clk(clk), .rst(rst), .en(en), .clr(clr), .drain(drain),
        .a_in(a_s[3:0]), .a_vld_in(av), .b_in(b_s[3:0]), .b_vld_in(bv), .c_in(c_s[7:0]), .c_vld_in(cv),
        .a_out(ao1), .a_vld_out(aov[1]), .b_out(bo1), .b_vld_out(bov[1]),
        .c_out(co1), .c_vld_out(cov[1]), .ovf(ovf[1]));
    pe_mac_param #(.DATA_W(8), .ACC_W(17), .SIGNED(1)) u2 (.clk(clk), .rst(rst), .en(en), .clr(clr), .drain(drain),
        .a_in(a_s[7:0]), .a_vld_in(av), .b_in(b_s[7:0]), .b_vld_in(bv), .c_in(c_s[16:0]), .c_vld_in(cv),
        .a_out(ao2), .a_vld_out(aov[2]), .b_out(bo2), .b_vld_out(bov[2]),
        .c_out(co2), .c_vld_out(cov[2]), .ovf(ovf[2]));
    pe_mac_param #(.DATA_W(4), .ACC_W(8), .SIGNED(1)) u3 (.clk(clk), .rst(rst), .en(en), .clr(clr), .drain(drain),
        .a_in(a_s[3:0]), .a_vld_in(av), .b_in(b_s[3:0]), .b_vld_in(bv), .c_in(c_s[7:0]), .c_vld_in(cv),
        .a_out(ao3), .a_vld_out(aov[3]), .b_out(bo3), .b_vld_out(bov[3]),
        .c_out(co3), .c_vld_out(cov[3]), .ovf(ovf[3]));
    pe_mac_param #(.PIPE_MUL(1)) u4 (.clk(clk), .rst(rst), .en(en), .clr(clr), .drain(drain),
        .a_in(a_s), .a_vld_in(av), .b_in(b_s), .b_vld_in(bv), .c_in(c_s), .c_vld_in(cv),
        .a_out(ao4), .a_vld_out(aov[4]), .b_out(bo4), .b_vld_out(bov[4]),
        .c_out(co4), .c_vld_out(cov[4]), .ovf(ovf[4]));
    pe_mac_param u5 (.clk(clk), .rst(rst), .en(en), .clr(clr), .drain(drain),
        .a_in(at), .a_vld_in(avt), .b_in(bt), .b_vld_in(bvt), .c_in(co0), .c_vld_in(cov[0]),
        .a_out(ao5), .a_vld_out(aov[5]), .b_out(bo5), .b_vld_out(bov[5]),
        .c_out(co5), .c_vld_out(cov[5]), .ovf(ovf[5]));

    assign co[0] = 64'(co0);  assign ao[0] = 64'(ao0);  assign bo[0] = 64'(bo0);
    assign co[1] = 64'(co1);  assign ao[1] = 64'(ao1);  assign bo[1] = 64'(bo1);
    assign co[2] = 64'(co2);  assign ao[2] = 64'(ao2);  assign bo[2] = 64'(bo2);
    assign co[3] = 64'(co3);  assign ao[3] = 64'(ao3);  assign bo[3] = 64'(bo3);
    assign co[4] = 64'(co4);  assign ao[4] = 64'(ao4);  assign bo[4] = 64'(bo4);
    assign co[5] = 64'(co5);  assign ao[5] = 64'(ao5);  assign bo[5] = 64'(bo5);

    function automatic longint msk(input longint v, input int w);
        return v & ((longint'(1) << w) - 1);
    endfunction

    function automatic longint sv(input longint v, input int w, input bit sg);
        longint m;
        m = msk(v, w);
        if (sg && m[w-1]) m = m - (longint'(1) << w);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one clock edge of every PE, computed from the arithmetic rules on integer values.
    task automatic model_step();
        longint h_acc = m_acc[0];
        bit     h_vld = m_vld[0];
        for (int i = 0; i < 6; i++) begin
            longint a, b, c, prod, ep, s, lo, hi;
            bit     ai, bi, ci, fire, ef, ec;
            if (i == 5) begin
                a = longint'(at); b = longint'(bt); ai = avt; bi = bvt; c = h_acc; ci = h_vld;
            end else begin
                a = longint'(a_s); b = longint'(b_s); ai = av; bi = bv;
                c = sv(longint'(c_s), AW[i], SG[i]); ci = cv;
            end
            if (!rst) begin
                m_acc[i] = 0; m_vld[i] = 0; m_ovf[i] = 0; m_a[i] = 0; m_b[i] = 0;
                m_av[i] = 0; m_bv[i] = 0; p_fire[i] = 0; p_clr[i] = 0; p_prod[i] = 0;
                continue;
            end
            if (!en) continue;
            m_a[i] = msk(a, DW[i]); m_b[i] = msk(b, DW[i]); m_av[i] = ai; m_bv[i] = bi;
            fire = ai & bi & ~drain;
            prod = sv(a, DW[i], SG[i]) * sv(b, DW[i], SG[i]);
            if (PM[i]) begin
                ef = p_fire[i]; ec = p_clr[i]; ep = p_prod[i];
                p_fire[i] = fire; p_clr[i] = clr & ~drain; p_prod[i] = prod;
            end else begin
                ef = fire; ec = clr; ep = prod;
            end
            hi = SG[i] ? (longint'(1) << (AW[i]-1)) - 1 : (longint'(1) << AW[i]) - 1;
            lo = SG[i] ? -(longint'(1) << (AW[i]-1)) : 0;
            if (drain) begin
                m_acc[i] = c; m_vld[i] = ci;
            end else if (ef) begin
                m_vld[i] = 1;
                if (ec) begin
                    m_acc[i] = ep; m_ovf[i] = 0;
                end else begin
                    s = m_acc[i] + ep;
                    if (s > hi) begin s = hi; m_ovf[i] = 1; end
                    else if (s < lo) begin s = lo; m_ovf[i] = 1; end
                    m_acc[i] = s;
                end
            end else if (ec) begin
                m_acc[i] = 0; m_vld[i] = 0; m_ovf[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("c_out[%0d]", i), co[i], 64'(msk(m_acc[i], AW[i])));
            chk($sformatf("c_vld[%0d]", i), 64'(cov[i]), 64'(m_vld[i]));
            chk($sformatf("ovf[%0d]", i), 64'(ovf[i]), 64'(m_ovf[i]));
            chk($sformatf("a_out[%0d]", i), ao[i], 64'(m_a[i]));
            chk($sformatf("b_out[%0d]", i), bo[i], 64'(m_b[i]));
            chk($sformatf("a_vld[%0d]", i), 64'(aov[i]), 64'(m_av[i]));
            chk($sformatf("b_vld[%0d]", i), 64'(bov[i]), 64'(m_bv[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic put(input bit f_av, input bit f_bv, input logic [15:0] fa, input logic [15:0] fb,
                       input bit f_clr, input bit f_drain);
        rst = 1'b1; en = 1'b1; av = f_av; bv = f_bv; a_s = fa; b_s = fb; clr = f_clr; drain = f_drain;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            m_acc[i] = 0; m_vld[i] = 0; m_ovf[i] = 0; m_a[i] = 0; m_b[i] = 0;
            m_av[i] = 0; m_bv[i] = 0; p_fire[i] = 0; p_clr[i] = 0; p_prod[i] = 0;
        end
        rst = 1'b0; en = 1'b0; clr = 1'b0; drain = 1'b0; av = 1'b0; bv = 1'b0; cv = 1'b0;
        a_s = '0; b_s = '0; c_s = '0; at = '0; bt = '0; avt = 1'b0; bvt = 1'b0;
        cycle();
        cycle();

        // Tile start (2,4) then (3,2); the tail PE builds 9 alongside.
        put(1, 1, 16'd2, 16'd4, 1, 0); at = 16'd3; bt = 16'd3; avt = 1'b1; bvt = 1'b1;
        cycle();
        chk("mac_first", co[0], 64'd8);
        chk("pipe_not_yet", co[4], 64'd0);
        put(1, 1, 16'd3, 16'd2, 0, 0); avt = 1'b0; bvt = 1'b0;
        cycle();
        chk("mac_second", co[0], 64'd14);
        chk("mac_vld", 64'(cov[0]), 64'd1);
        chk("fwd_a", ao[0], 64'd3);
        chk("pipe_two_edges", co[4], 64'd8);
        chk("tail_before", co[5], 64'd9);

        // Two-PE drain with an empty head input.
        put(0, 0, 16'd0, 16'd0, 0, 1); c_s = '0; cv = 1'b0;
        cycle();
        chk("drain_tail1", co[5], 64'd14);
        chk("drain_head", co[0], 64'd0);
        chk("drain_head_vld", 64'(cov[0]), 64'd0);
        cycle();
        chk("drain_tail2", co[5], 64'd0);

        // Unsigned clamp at 255, then clr.
        put(1, 1, 16'd15, 16'd15, 1, 0);
        cycle();
        chk("u8_first", co[1], 64'd225);
        put(1, 1, 16'd15, 16'd15, 0, 0);
        cycle();
        chk("u8_clamp", co[1], 64'd255);
        chk("u8_ovf", 64'(ovf[1]), 64'd1);
        put(0, 0, 16'd0, 16'd0, 1, 0);
        cycle();
        chk("u8_clr_ovf", 64'(ovf[1]), 64'd0);
        chk("u8_clr_c", co[1], 64'd0);

        // Signed accumulate: -12 then -17.
        put(1, 1, 16'hFFFD, 16'd4, 1, 0);
        cycle();
        chk("s17_first", co[2], 64'h1FFF4);
        put(1, 1, 16'd5, 16'hFFFF, 0, 0);
        cycle();
        chk("s17_second", co[2], 64'h1FFEF);

        // Signed clamp at -128 then +127.
        put(1, 1, 16'hFFF8, 16'd7, 1, 0);
        cycle();
        put(1, 1, 16'hFFF8, 16'd7, 0, 0);
        cycle();
        cycle();
        chk("s8_neg_clamp", co[3], 64'h80);
        chk("s8_neg_ovf", 64'(ovf[3]), 64'd1);
        put(1, 1, 16'hFFF8, 16'hFFF8, 1, 0);
        cycle();
        put(1, 1, 16'hFFF8, 16'hFFF8, 0, 0);
        cycle();
        chk("s8_pos_clamp", co[3], 64'h7F);

        // Freeze for five cycles with toggling inputs, then resume.
        for (int k = 0; k < 5; k++) begin
            en = 1'b0; clr = k[0]; drain = k[1]; av = ~k[0]; bv = 1'b1;
            a_s = 16'($urandom); b_s = 16'($urandom); c_s = {1'($urandom), $urandom}; cv = 1'b1;
            at = 16'($urandom); bt = 16'($urandom); avt = 1'b1; bvt = 1'b1;
            cycle();
        end
        put(1, 1, 16'd1, 16'd1, 0, 0); avt = 1'b0; bvt = 1'b0;
        cycle();

        // Reset while a product sits in the pipe register.
        put(1, 1, 16'd2, 16'd4, 1, 0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("pipe_rst", co[4], 64'd0);
        put(0, 0, 16'd0, 16'd0, 0, 0);
        cycle();
        chk("pipe_rst_after", co[4], 64'd0);

        for (int k = 0; k < 300; k++) begin
            rst   = ($urandom_range(0, 49) != 0);
            en    = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 6) == 0);
            drain = ($urandom_range(0, 8) == 0);
            av    = ($urandom_range(0, 9) < 7);
            bv    = ($urandom_range(0, 9) < 7);
            cv    = 1'($urandom);
            a_s   = 16'($urandom);
            b_s   = 16'($urandom);
            c_s   = {1'($urandom), $urandom};
            avt   = ($urandom_range(0, 9) < 7);
            bvt   = ($urandom_range(0, 9) < 7);
            at    = 16'($urandom);
            bt    = 16'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
